// File: rtl/regfile_writeback.sv
// Writeback stage: MEM/WB pipeline register, load alignment/extension, result select,
// register-file write port and retired-instruction counter.
module regfile_writeback #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic             wb_stall,
    input  logic             flush,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_read_data,
    input  logic [2:0]       mem_funct3,
    input  logic [1:0]       mem_wb_sel,
    input  logic [XLEN-1:0]  mem_pc_plus4,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    output logic [XLEN-1:0]  WriteData,
    output logic [4:0]       rd,
    output logic             RegWrite,
    output logic             wb_valid,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    logic             wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]  alu_q, alu_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic [XLEN-1:0]  pc4_q, pc4_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       wb_sel_q, wb_sel_d;
    logic [4:0]       rd_q, rd_d;
    logic             reg_write_q, reg_write_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       off;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;
    logic [XLEN-1:0]  load_v;

    assign mem_ready = ~wb_stall;

    // Next state: flush beats stall beats capture; retirement counts the instruction leaving WB.
    always_comb begin
        wb_valid_d  = wb_valid_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        pc4_d       = pc4_q;
        funct3_d    = funct3_q;
        wb_sel_d    = wb_sel_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        cnt_d       = cnt_q + CNT_W'(wb_valid_q & ~wb_stall);

        if (flush) begin
            wb_valid_d  = 1'b0;
            alu_d       = '0;
            rdata_d     = '0;
            pc4_d       = '0;
            funct3_d    = '0;
            wb_sel_d    = '0;
            rd_d        = '0;
            reg_write_d = 1'b0;
        end else if (!wb_stall) begin
            wb_valid_d  = mem_valid;
            alu_d       = mem_alu_result;
            rdata_d     = mem_read_data;
            pc4_d       = mem_pc_plus4;
            funct3_d    = mem_funct3;
            wb_sel_d    = mem_wb_sel;
            rd_d        = mem_rd;
            reg_write_d = mem_reg_write;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid_q  <= 1'b0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
            funct3_q    <= '0;
            wb_sel_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wb_valid_q  <= wb_valid_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            pc4_q       <= pc4_d;
            funct3_q    <= funct3_d;
            wb_sel_q    <= wb_sel_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            cnt_q       <= cnt_d;
        end
    end

    // Lane pick from the doubleword; low offset bits below the access size are ignored.
    always_comb begin
        off    = alu_q[2:0];
        byte_v = rdata_q[{off, 3'b000} +: 8];
        half_v = rdata_q[{off[2:1], 4'b0000} +: 16];
        word_v = rdata_q[{off[2], 5'b00000} +: 32];
        case (funct3_q)
            3'b000:  load_v = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b001:  load_v = {{(XLEN-16){half_v[15]}}, half_v};
            3'b010:  load_v = {{(XLEN-32){word_v[31]}}, word_v};
            3'b100:  load_v = {{(XLEN-8){1'b0}}, byte_v};
            3'b101:  load_v = {{(XLEN-16){1'b0}}, half_v};
            3'b110:  load_v = {{(XLEN-32){1'b0}}, word_v};
            default: load_v = rdata_q;
        endcase
    end

    always_comb begin
        case (wb_sel_q)
            SEL_LOAD: WriteData = load_v;
            SEL_LINK: WriteData = pc4_q;
            default:  WriteData = alu_q;
        endcase
    end

    // A stalled WB holds its instruction but must not write it twice.
    assign RegWrite      = wb_valid_q & reg_write_q & (rd_q != 5'd0) & ~wb_stall;
    assign rd            = rd_q;
    assign wb_valid      = wb_valid_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed cases plus randomized traffic against a behavioural model.
module tb_regfile_writeback;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_valid, mem_ready, wb_stall, flush;
    logic [XLEN-1:0]  mem_alu_result, mem_read_data, mem_pc_plus4;
    logic [2:0]       mem_funct3;
    logic [1:0]       mem_wb_sel;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic [XLEN-1:0]  WriteData;
    logic [4:0]       rd;
    logic             RegWrite, wb_valid;
    logic [CNT_W-1:0] retired_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: the instruction currently sitting in WB, plus the retire count.
    logic             m_valid;
    logic [63:0]      m_alu, m_data, m_pc4;
    logic [2:0]       m_f3;
    logic [1:0]       m_sel;
    logic [4:0]       m_rd;
    logic             m_rw;
    logic [CNT_W-1:0] m_cnt;

    regfile_writeback #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .wb_stall(wb_stall), .flush(flush),
        .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
        .mem_funct3(mem_funct3), .mem_wb_sel(mem_wb_sel),
        .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write),
        .WriteData(WriteData), .rd(rd), .RegWrite(RegWrite),
        .wb_valid(wb_valid), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Size-generic load: access of n bytes at the n-aligned offset, then extend.
    function automatic logic [63:0] load_value(input logic [2:0] f3, input logic [63:0] data,
                                              input logic [2:0] off);
        int unsigned n, a;
        logic [63:0] v, mask;
        if (f3[1:0] == 2'b11) return data;
        n    = 1 << f3[1:0];
        a    = (int'(off) / n) * n;
        v    = data >> (8 * a);
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = v & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [63:0] exp_wdata();
        if (m_sel == 2'd1) return load_value(m_f3, m_data, m_alu[2:0]);
        if (m_sel == 2'd2) return m_pc4;
        return m_alu;
    endfunction

    task automatic model_clear(input logic clr_cnt);
        m_valid = 0; m_alu = 0; m_data = 0; m_pc4 = 0;
        m_f3 = 0; m_sel = 0; m_rd = 0; m_rw = 0;
        if (clr_cnt) m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        logic exp_rw;
        exp_rw = m_valid && m_rw && (m_rd != 0) && !wb_stall;
        check({tag, ".wb_valid"}, 64'(wb_valid), 64'(m_valid));
        check({tag, ".rd"}, 64'(rd), 64'(m_rd));
        check({tag, ".WriteData"}, WriteData, exp_wdata());
        check({tag, ".RegWrite"}, 64'(RegWrite), 64'(exp_rw));
        check({tag, ".count"}, 64'(retired_count), 64'(m_cnt));
        check({tag, ".mem_ready"}, 64'(mem_ready), 64'(!wb_stall));
    endtask

    // One clock edge, then advance the model with the inputs that were presented at it.
    task automatic step();
        @(posedge clk);
        if (!reset) begin
            model_clear(1'b1);
        end else begin
            if (m_valid && !wb_stall) m_cnt = m_cnt + 1;
            if (flush) model_clear(1'b0);
            else if (!wb_stall) begin
                m_valid = mem_valid; m_alu = mem_alu_result; m_data = mem_read_data;
                m_pc4 = mem_pc_plus4; m_f3 = mem_funct3; m_sel = mem_wb_sel;
                m_rd = mem_rd; m_rw = mem_reg_write;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic st, input logic fl, input logic [63:0] alu,
                          input logic [63:0] data, input logic [2:0] f3, input logic [1:0] sel,
                          input logic [4:0] rdi, input logic rw);
        mem_valid = v; wb_stall = st; flush = fl; mem_alu_result = alu;
        mem_read_data = data; mem_funct3 = f3; mem_wb_sel = sel;
        mem_pc_plus4 = {$urandom, $urandom}; mem_rd = rdi; mem_reg_write = rw;
    endtask

    task automatic randomize_in();
        set_in(1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
               {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom), 2'($urandom),
               ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom),
               2'($urandom), 5'($urandom), 1'($urandom));
    endtask

    logic [CNT_W-1:0] cnt_hold;

    initial begin
        reset = 1'b0;
        model_clear(1'b1);
        randomize_in();
        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            randomize_in();
            #1 check_all("reset");
            check("reset.WriteData0", WriteData, 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // lb sign-extends byte lane 1
        set_in(1, 0, 0, 64'h1000_0001, 64'h0000_0000_0000_8000, 3'b000, 2'b01, 5'd5, 1);
        #1 check_all("pre_lb");
        step();
        idle();
        #1 check_all("lb");
        check("lb.const", WriteData, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb.rd", 64'(rd), 64'd5);
        check("lb.we", 64'(RegWrite), 64'd1);

        set_in(1, 0, 0, 64'h2000_0006, 64'hBEEF_0000_0000_0000, 3'b101, 2'b01, 5'd6, 1);
        step();
        set_in(1, 0, 0, 64'h2000_0006, 64'hBEEF_0000_0000_0000, 3'b001, 2'b01, 5'd6, 1);
        #1 check_all("lhu");
        check("lhu.const", WriteData, 64'h0000_0000_0000_BEEF);
        step();
        idle();
        #1 check_all("lh");
        check("lh.const", WriteData, 64'hFFFF_FFFF_FFFF_BEEF);

        // x0 destination retires without writing
        set_in(1, 0, 0, 64'd42, 64'd0, 3'b000, 2'b00, 5'd0, 1);
        step();
        idle();
        cnt_hold = m_cnt;
        #1 check_all("x0");
        check("x0.we", 64'(RegWrite), 64'd0);
        step();
        check("x0.count", 64'(retired_count), 64'(cnt_hold + 1));

        // Stall holds WB for three cycles, then one write and the next instruction
        set_in(1, 0, 0, 64'd7, 64'd0, 3'b011, 2'b00, 5'd3, 1);
        step();
        cnt_hold = m_cnt;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 64'd99, 64'd0, 3'b011, 2'b00, 5'd9, 1);
            #1 check_all("stall");
            check("stall.rd", 64'(rd), 64'd3);
            check("stall.data", WriteData, 64'd7);
            check("stall.we", 64'(RegWrite), 64'd0);
            check("stall.count", 64'(retired_count), 64'(cnt_hold));
            step();
        end
        set_in(1, 0, 0, 64'd99, 64'd0, 3'b011, 2'b00, 5'd9, 1);
        #1 check_all("release");
        check("release.we", 64'(RegWrite), 64'd1);
        check("release.rd", 64'(rd), 64'd3);
        step();
        idle();
        #1 check_all("next");
        check("next.rd", 64'(rd), 64'd9);
        check("next.data", WriteData, 64'd99);

        // Flush wins over stall
        set_in(1, 0, 0, 64'd11, 64'd0, 3'b000, 2'b00, 5'd4, 1);
        step();
        set_in(1, 1, 1, 64'd12, 64'd0, 3'b000, 2'b00, 5'd8, 1);
        step();
        idle();
        #1 check_all("flush");
        check("flush.valid", 64'(wb_valid), 64'd0);
        check("flush.we", 64'(RegWrite), 64'd0);

        // Randomized traffic with occasional asynchronous reset pulses
        for (int i = 0; i < 400; i++) begin
            randomize_in();
            #1 check_all("rand");
            if (i % 97 == 50) begin
                #2 reset = 1'b0;
                model_clear(1'b1);
                #1 check_all("async_rst");
                check("async_rst.count", 64'(retired_count), 64'd0);
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
